// File: rtl/mul8_pp_issue.sv
`default_nettype none
// ============================================================================
//  Module      : mul8_pp_issue
//  Description : Operand-issue and partial-product generation stage for an
//                8x8 unsigned multiplier. A 2-entry operand FIFO feeds an
//                output register that presents the 64 AND-array bits as 15
//                column buses. Valid/ready on both sides, and a counter of
//                completed output handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul8_pp_issue #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             pp_valid,
    input  logic             pp_ready,
    output logic             pp_col0,
    output logic [1:0]       pp_col1,
    output logic [2:0]       pp_col2,
    output logic [3:0]       pp_col3,
    output logic [4:0]       pp_col4,
    output logic [5:0]       pp_col5,
    output logic [6:0]       pp_col6,
    output logic [7:0]       pp_col7,
    output logic [6:0]       pp_col8,
    output logic [5:0]       pp_col9,
    output logic [4:0]       pp_col10,
    output logic [3:0]       pp_col11,
    output logic [2:0]       pp_col12,
    output logic [1:0]       pp_col13,
    output logic             pp_col14,
    output logic [TAG_W-1:0] pp_tag,
    output logic [CNT_W-1:0] op_count
);

    // FIFO occupancy state
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } fifo_state_t;

    // Bit offset of column c inside the flat 64-bit partial-product vector.
    // Columns 0..7 grow by one bit each, columns 8..14 shrink by one.
    function automatic int col_off(input int c);
        int s;
        s = 0;
        for (int j = 0; j < c; j++) begin
            s += (j < 8) ? (j + 1) : (15 - j);
        end
        return s;
    endfunction

    fifo_state_t      state_q, state_d;
    logic [7:0]       fa_q [2];
    logic [7:0]       fb_q [2];
    logic [TAG_W-1:0] ft_q [2];
    logic [7:0]       fa_d [2];
    logic [7:0]       fb_d [2];
    logic [TAG_W-1:0] ft_d [2];

    logic             pp_valid_q, pp_valid_d;
    logic [63:0]      pp_q;
    logic [TAG_W-1:0] tag_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ready_en_q;

    logic             w_in_hs;
    logic             w_out_hs;
    logic             w_free;
    logic             w_pop;
    logic             w_bypass;
    logic             w_push;
    logic             w_load;
    logic [7:0]       w_ld_a;
    logic [7:0]       w_ld_b;
    logic [TAG_W-1:0] w_ld_tag;
    logic [63:0]      w_pp;

    // in_ready is held low until the first clock edge out of reset
    assign in_ready = ready_en_q && (state_q != S_TWO) && !flush;

    assign w_in_hs  = in_valid && in_ready;
    assign w_out_hs = pp_valid_q && pp_ready;
    assign w_free   = !pp_valid_q || pp_ready;
    // Queued entries always go first; only an empty FIFO may be bypassed
    assign w_pop    = w_free && (state_q != S_EMPTY);
    assign w_bypass = w_free && (state_q == S_EMPTY) && w_in_hs;
    assign w_push   = w_in_hs && !w_bypass;
    assign w_load   = w_pop || w_bypass;

    assign w_ld_a   = w_pop ? fa_q[0] : in_a;
    assign w_ld_b   = w_pop ? fb_q[0] : in_b;
    assign w_ld_tag = w_pop ? ft_q[0] : in_tag;

    // AND array laid out column by column, lowest a-index first in each column
    generate
        for (genvar c = 0; c < 15; c++) begin : g_col
            localparam int LO = (c > 7) ? (c - 7) : 0;
            localparam int HI = (c < 7) ? c : 7;
            for (genvar i = LO; i <= HI; i++) begin : g_bit
                assign w_pp[col_off(c) + i - LO] = w_ld_a[i] & w_ld_b[c - i];
            end
        end
    endgenerate

    // Occupancy next state; a push and pop together leave the count unchanged
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else if (w_push && !w_pop) begin
            case (state_q)
                S_EMPTY: state_d = S_ONE;
                S_ONE:   state_d = S_TWO;
                default: state_d = state_q;
            endcase
        end else if (w_pop && !w_push) begin
            case (state_q)
                S_TWO:   state_d = S_ONE;
                S_ONE:   state_d = S_EMPTY;
                default: state_d = state_q;
            endcase
        end
    end

    // FIFO storage: pop shifts slot 1 to the head, push writes the first free slot
    always_comb begin
        fa_d = fa_q;
        fb_d = fb_q;
        ft_d = ft_q;
        if (w_pop) begin
            fa_d[0] = fa_q[1];
            fb_d[0] = fb_q[1];
            ft_d[0] = ft_q[1];
        end
        if (w_push) begin
            if ((state_q == S_ONE) && !w_pop) begin
                fa_d[1] = in_a;
                fb_d[1] = in_b;
                ft_d[1] = in_tag;
            end else begin
                fa_d[0] = in_a;
                fb_d[0] = in_b;
                ft_d[0] = in_tag;
            end
        end
    end

    // Output-register valid: cleared by flush, set on load, dropped when drained
    always_comb begin
        pp_valid_d = pp_valid_q;
        if (flush) begin
            pp_valid_d = 1'b0;
        end else if (w_load) begin
            pp_valid_d = 1'b1;
        end else if (w_free) begin
            pp_valid_d = 1'b0;
        end
    end

    // State, FIFO and ready-enable registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            ready_en_q <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                fa_q[k] <= '0;
                fb_q[k] <= '0;
                ft_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            fa_q       <= fa_d;
            fb_q       <= fb_d;
            ft_q       <= ft_d;
        end
    end

    // Output register: column bits and tag only change on a load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pp_valid_q <= 1'b0;
            pp_q       <= '0;
            tag_q      <= '0;
        end else begin
            pp_valid_q <= pp_valid_d;
            if (w_load) begin
                pp_q  <= w_pp;
                tag_q <= w_ld_tag;
            end
        end
    end

    // Completed-issue counter; flush does not affect it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (w_out_hs) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign pp_valid = pp_valid_q;
    assign pp_tag   = tag_q;
    assign op_count = cnt_q;

    assign pp_col0  = pp_q[0];
    assign pp_col1  = pp_q[2:1];
    assign pp_col2  = pp_q[5:3];
    assign pp_col3  = pp_q[9:6];
    assign pp_col4  = pp_q[14:10];
    assign pp_col5  = pp_q[20:15];
    assign pp_col6  = pp_q[27:21];
    assign pp_col7  = pp_q[35:28];
    assign pp_col8  = pp_q[42:36];
    assign pp_col9  = pp_q[48:43];
    assign pp_col10 = pp_q[53:49];
    assign pp_col11 = pp_q[57:54];
    assign pp_col12 = pp_q[60:58];
    assign pp_col13 = pp_q[62:61];
    assign pp_col14 = pp_q[63];

endmodule
`default_nettype wire

// File: tb/tb_mul8_pp_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul8_pp_issue
//  Description : Self-checking bench for mul8_pp_issue. A queue model of the
//                work in flight predicts every output each cycle; directed
//                literal checks pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul8_pp_issue;

    localparam int TAG_W = 4;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [7:0]       a;
        logic [7:0]       b;
        logic [TAG_W-1:0] tag;
    } item_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             pp_ready = 1'b0;
    logic [7:0]       in_a = '0;
    logic [7:0]       in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             in_ready;
    logic             pp_valid;
    logic             pp_col0;
    logic [1:0]       pp_col1;
    logic [2:0]       pp_col2;
    logic [3:0]       pp_col3;
    logic [4:0]       pp_col4;
    logic [5:0]       pp_col5;
    logic [6:0]       pp_col6;
    logic [7:0]       pp_col7;
    logic [6:0]       pp_col8;
    logic [5:0]       pp_col9;
    logic [4:0]       pp_col10;
    logic [3:0]       pp_col11;
    logic [2:0]       pp_col12;
    logic [1:0]       pp_col13;
    logic             pp_col14;
    logic [TAG_W-1:0] pp_tag;
    logic [CNT_W-1:0] op_count;

    mul8_pp_issue #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .pp_valid(pp_valid), .pp_ready(pp_ready),
        .pp_col0(pp_col0), .pp_col1(pp_col1), .pp_col2(pp_col2),
        .pp_col3(pp_col3), .pp_col4(pp_col4), .pp_col5(pp_col5),
        .pp_col6(pp_col6), .pp_col7(pp_col7), .pp_col8(pp_col8),
        .pp_col9(pp_col9), .pp_col10(pp_col10), .pp_col11(pp_col11),
        .pp_col12(pp_col12), .pp_col13(pp_col13), .pp_col14(pp_col14),
        .pp_tag(pp_tag), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Columns gathered into a uniform zero-padded view
    logic [7:0] colv [15];
    always_comb begin
        colv[0]  = {7'b0, pp_col0};
        colv[1]  = {6'b0, pp_col1};
        colv[2]  = {5'b0, pp_col2};
        colv[3]  = {4'b0, pp_col3};
        colv[4]  = {3'b0, pp_col4};
        colv[5]  = {2'b0, pp_col5};
        colv[6]  = {1'b0, pp_col6};
        colv[7]  = pp_col7;
        colv[8]  = {1'b0, pp_col8};
        colv[9]  = {2'b0, pp_col9};
        colv[10] = {3'b0, pp_col10};
        colv[11] = {4'b0, pp_col11};
        colv[12] = {5'b0, pp_col12};
        colv[13] = {6'b0, pp_col13};
        colv[14] = {7'b0, pp_col14};
    end

    // Expected column c: bit k is a[i]&b[c-i], i = max(0,c-7)+k
    function automatic logic [7:0] exp_col(input logic [7:0] a, input logic [7:0] b, input int c);
        logic [7:0] r;
        int lo;
        int hi;
        r  = '0;
        lo = (c > 7) ? c - 7 : 0;
        hi = (c < 7) ? c : 7;
        for (int i = lo; i <= hi; i++) begin
            r[i - lo] = a[i] & b[c - i];
        end
        return r;
    endfunction

    // Model: everything accepted and not yet consumed, oldest first.
    // The oldest item is on the column buses whenever the queue is non-empty.
    item_t q[$];
    int    m_cnt = 0;
    bit    alive = 1'b0;
    int    accepted = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_cnt = 0;
            alive = 1'b0;
        end else begin
            bit rdy;
            rdy = alive && (q.size() < 3) && !flush;
            if ((q.size() > 0) && pp_ready) begin
                void'(q.pop_front());
                m_cnt++;
            end
            if (flush) q.delete();
            if (in_valid && rdy) begin
                q.push_back('{a: in_a, b: in_b, tag: in_tag});
                accepted++;
            end
            alive = 1'b1;
        end
    end

    logic        prev_stall = 1'b0;
    logic [67:0] snap = '0;

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        bit          m_ready;
        logic [15:0] wsum;
        logic [67:0] cur;
        m_ready = alive && (q.size() < 3) && !flush;
        chk("in_ready", 64'(in_ready), 64'(m_ready));
        chk("pp_valid", 64'(pp_valid), 64'(q.size() > 0));
        chk("op_count", 64'(op_count), 64'(m_cnt % 16));
        cur = {pp_tag, pp_col14, pp_col13, pp_col12, pp_col11, pp_col10, pp_col9, pp_col8,
               pp_col7, pp_col6, pp_col5, pp_col4, pp_col3, pp_col2, pp_col1, pp_col0};
        if (q.size() > 0) begin
            chk("pp_tag", 64'(pp_tag), 64'(q[0].tag));
            wsum = '0;
            for (int c = 0; c < 15; c++) begin
                chk($sformatf("col%0d", c), 64'(colv[c]), 64'(exp_col(q[0].a, q[0].b, c)));
                for (int k = 0; k < 8; k++) begin
                    if (colv[c][k]) wsum += 16'(1) << c;
                end
            end
            chk("weighted_sum", 64'(wsum), 64'(q[0].a * q[0].b));
        end
        if (prev_stall && rst_n) begin
            chk("stall_hold", 64'(cur), 64'(snap));
        end
        prev_stall = pp_valid && !pp_ready && !flush && rst_n;
        snap       = cur;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [TAG_W-1:0] t);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        int target;

        // Reset state
        #3;
        chk("rst_pp_valid", 64'(pp_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_op_count", 64'(op_count), 64'd0);
        chk("rst_pp_tag",   64'(pp_tag),   64'd0);
        chk("rst_col7",     64'(pp_col7),  64'd0);
        #24;
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        // All-ones operands
        pp_ready = 1'b1;
        send(8'hFF, 8'hFF, 4'd1);
        chk("ff_valid", 64'(pp_valid), 64'd1);
        chk("ff_col7",  64'(pp_col7),  64'hFF);
        chk("ff_col0",  64'(pp_col0),  64'd1);
        chk("ff_col14", 64'(pp_col14), 64'd1);
        chk("ff_col8",  64'(pp_col8),  64'h7F);
        chk("ff_tag",   64'(pp_tag),   64'd1);
        step();
        chk("ff_count", 64'(op_count), 64'd1);
        chk("ff_drained", 64'(pp_valid), 64'd0);

        // Sparse operands
        send(8'h81, 8'h01, 4'd2);
        chk("x81_col0", 64'(pp_col0), 64'd1);
        chk("x81_col7", 64'(pp_col7), 64'h80);
        chk("x81_col1", 64'(pp_col1), 64'd0);
        chk("x81_col8", 64'(pp_col8), 64'd0);
        step();
        send(8'h00, 8'hA5, 4'd3);
        for (int c = 0; c < 15; c++) chk($sformatf("zero_col%0d", c), 64'(colv[c]), 64'd0);
        step();

        // Backpressure: three pairs fill OREG plus FIFO
        pp_ready = 1'b0;
        in_valid = 1'b1;
        in_a = 8'h12; in_b = 8'h34; in_tag = 4'd1; step();
        in_a = 8'h56; in_b = 8'h78; in_tag = 4'd2; step();
        in_a = 8'h9A; in_b = 8'hBC; in_tag = 4'd3; step();
        in_valid = 1'b0;
        chk("bp_ready_low", 64'(in_ready), 64'd0);
        chk("bp_tag_hold",  64'(pp_tag),   64'd1);
        pp_ready = 1'b1;
        step();
        chk("bp_tag2", 64'(pp_tag), 64'd2);
        step();
        chk("bp_tag3", 64'(pp_tag), 64'd3);
        step();
        chk("bp_empty", 64'(pp_valid), 64'd0);
        chk("bp_count", 64'(op_count), 64'd6);

        // Flush with FIFO full and OREG valid
        pp_ready = 1'b0;
        in_valid = 1'b1;
        in_tag = 4'd4; step();
        in_tag = 4'd5; step();
        in_tag = 4'd6; step();
        in_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("flush_ready_low", 64'(in_ready), 64'd0);
        step();
        flush = 1'b0;
        #1;
        chk("flush_valid", 64'(pp_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        chk("flush_count", 64'(op_count), 64'd6);

        // Ten more handshakes carry the 4-bit counter through its wrap
        pp_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            in_valid = 1'b1;
            in_a = 8'(n * 17); in_b = 8'(n * 29 + 3); in_tag = 4'(n);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("wrap_count", 64'(op_count), 64'd0);

        // Streaming, one per cycle
        for (int n = 0; n < 100; n++) begin
            in_valid = 1'b1;
            in_a = 8'($urandom); in_b = 8'($urandom); in_tag = 4'($urandom);
            step();
        end
        in_valid = 1'b0;
        step();

        // Random valid/ready
        target = accepted + 1000;
        cyc = 0;
        while (accepted < target && cyc < 8000) begin
            in_valid = 1'($urandom_range(0, 1));
            pp_ready = 1'($urandom_range(0, 1));
            in_a = 8'($urandom); in_b = 8'($urandom); in_tag = 4'($urandom);
            step();
            cyc++;
        end
        tests++;
        if (accepted < target) begin
            fails++;
            $display("FAIL random_progress: got %0d accepted expected %0d", accepted, target);
        end
        in_valid = 1'b0;
        pp_ready = 1'b1;
        repeat (5) step();

        // Reset in the middle of queued work
        pp_ready = 1'b0;
        in_valid = 1'b1;
        in_a = 8'hC3; in_b = 8'h3C; in_tag = 4'd9; step();
        in_tag = 4'd10; step();
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(pp_valid), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_col7",  64'(pp_col7),  64'd0);
        chk("mid_rst_tag",   64'(pp_tag),   64'd0);
        chk("mid_rst_count", 64'(op_count), 64'd0);
        #2;
        rst_n = 1'b1;
        pp_ready = 1'b1;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
